// File: rtl/uart_rx_mem_writer.sv
// Packs a UART receive byte stream little-endian into 32-bit words and writes them
// to a single-port memory via one-cycle Avalon-MM writes with byteenable.
module uart_rx_mem_writer #(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 100000,
  parameter int CNT_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_byte_count,
  input  logic              flush,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bytes_written
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_bytes_written;
  logic [1:0]         r_lane;
  logic [3:0]         r_be;
  logic [31:0]        r_data;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_mem_cs;
  logic               r_mem_wr;
  logic [3:0]         r_mem_be;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_data;

  logic               w_accept;
  logic               w_word_end;
  logic [31:0]        w_data_next;
  logic [3:0]         w_be_next;
  logic [CNT_W-1:0]   w_be_cnt;
  logic [ADDR_W-1:0]  w_addr_next;

  // r_in_ready is only ever set while collecting, so it doubles as the state qualifier
  assign w_accept = in_valid & r_in_ready;

  always_comb begin
    w_data_next = r_data;
    w_be_next   = r_be;
    if (w_accept) begin
      w_data_next[{r_lane, 3'b000} +: 8] = in_data;
      w_be_next[r_lane]                  = 1'b1;
    end
  end

  // A flush alongside an accepted byte always has a non-empty word to write
  always_comb begin
    w_word_end = 1'b0;
    if (w_accept)
      w_word_end = (r_lane == 2'd3) || (r_remaining == CNT_W'(1)) || flush;
    else
      w_word_end = flush && (r_lane != 2'd0);
  end

  assign w_be_cnt    = CNT_W'(r_be[0]) + CNT_W'(r_be[1]) + CNT_W'(r_be[2]) + CNT_W'(r_be[3]);
  assign w_addr_next = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_bytes_written <= '0;
      r_lane          <= '0;
      r_be            <= '0;
      r_data          <= '0;
      r_in_ready      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_mem_cs        <= 1'b0;
      r_mem_wr        <= 1'b0;
      r_mem_be        <= '0;
      r_mem_addr      <= '0;
      r_mem_data      <= '0;
    end else begin
      r_done   <= 1'b0;
      r_mem_cs <= 1'b0;
      r_mem_wr <= 1'b0;
      r_mem_be <= '0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_bytes_written <= '0;
            r_lane          <= '0;
            r_be            <= '0;
            r_data          <= '0;
            if (cfg_byte_count != '0) begin
              r_addr      <= cfg_base_addr;
              r_remaining <= cfg_byte_count;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_COLLECT;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_data      <= w_data_next;
            r_be        <= w_be_next;
            r_lane      <= r_lane + 2'd1;
            r_remaining <= r_remaining - CNT_W'(1);
          end
          if (w_word_end) begin
            r_mem_cs   <= 1'b1;
            r_mem_wr   <= 1'b1;
            r_mem_be   <= w_be_next;
            r_mem_addr <= r_addr;
            r_mem_data <= w_data_next;
            r_in_ready <= 1'b0;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_bytes_written <= r_bytes_written + w_be_cnt;
          r_addr          <= w_addr_next;
          r_lane          <= '0;
          r_be            <= '0;
          r_data          <= '0;
          if (r_remaining == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign bytes_written  = r_bytes_written;
  assign mem_chipselect = r_mem_cs;
  assign mem_write      = r_mem_wr;
  assign mem_byteenable = r_mem_be;
  assign mem_address    = r_mem_addr;
  assign mem_writedata  = r_mem_data;

endmodule

// File: tb/tb_uart_rx_mem_writer.sv
// Scoreboard bench for uart_rx_mem_writer: expected writes are queued by the
// stimulus and popped by an independent monitor on every mem_write cycle.
module tb_uart_rx_mem_writer;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 100000;
  localparam int CNT_W  = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [CNT_W-1:0]  cfg_byte_count;
  logic              flush;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bytes_written;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  uart_rx_mem_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_byte_count (cfg_byte_count),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .busy           (busy),
    .done           (done),
    .bytes_written  (bytes_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && mem_write) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h be=%h, required no write",
                 mem_address, mem_writedata, mem_byteenable);
      end else begin
        e = exp_q.pop_front();
        if (mem_address !== e.addr || mem_writedata !== e.data ||
            mem_byteenable !== e.be || mem_chipselect !== 1'b1) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h be=%h cs=%b, required addr=%0d data=%h be=%h cs=1",
                   mem_address, mem_writedata, mem_byteenable, mem_chipselect, e.addr, e.data, e.be);
        end
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_in_write: got %b, required 0", in_ready);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    cfg_start      = 1'b1;
    cfg_base_addr  = base;
    cfg_byte_count = cnt;
    tick();
    cfg_start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got no accept, required accept of %h", b);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input logic [CNT_W-1:0] exp_bw, input logic chk_bw);
    logic seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check("done_seen", 64'(seen), 64'd1);
    if (chk_bw) check("bytes_written", 64'(bytes_written), 64'(exp_bw));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    tick();
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    check(name, 64'({in_ready, busy, done, mem_chipselect, mem_write, mem_byteenable,
                     mem_address, mem_writedata, bytes_written}), 64'd0);
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_byte_count = '0;
    flush = 1'b0; in_data = '0; in_valid = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    reset = 1'b0;
    tick();

    // Two full words back-to-back
    expect_wr(17'h00010, 32'h44332211, 4'hF);
    expect_wr(17'h00011, 32'h88776655, 4'hF);
    start(17'h00010, 19'd8);
    for (int i = 1; i <= 8; i++) begin b = 8'(i * 8'h11); send_byte(b); end
    wait_done(19'd8, 1'b1);

    // Partial final word
    expect_wr(17'h00020, 32'h44332211, 4'hF);
    expect_wr(17'h00021, 32'h00006655, 4'h3);
    start(17'h00020, 19'd6);
    for (int i = 1; i <= 6; i++) begin b = 8'(i * 8'h11); send_byte(b); end
    wait_done(19'd6, 1'b1);

    // Flush after two bytes, then a flush on an empty word is ignored
    expect_wr(17'h00030, 32'h0000A2A1, 4'h3);
    expect_wr(17'h00031, 32'hA6A5A4A3, 4'hF);
    expect_wr(17'h00032, 32'hAAA9A8A7, 4'hF);
    start(17'h00030, 19'd10);
    send_byte(8'hA1);
    send_byte(8'hA2);
    pulse_flush();
    repeat (3) tick();
    pulse_flush();
    repeat (2) tick();
    for (int i = 3; i <= 10; i++) begin b = 8'(8'hA0 + i); send_byte(b); end
    wait_done(19'd10, 1'b1);

    // Address wrap
    expect_wr(17'd99999, 32'h04030201, 4'hF);
    expect_wr(17'd0,     32'h08070605, 4'hF);
    start(17'd99999, 19'd8);
    for (int i = 1; i <= 8; i++) begin b = 8'(i); send_byte(b); end
    wait_done(19'd8, 1'b1);

    // Random gaps with an ignored mid-transfer start
    expect_wr(17'h00040, 32'h44332211, 4'hF);
    expect_wr(17'h00041, 32'h88776655, 4'hF);
    start(17'h00040, 19'd8);
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == 4) start(17'h00077, 19'd3);
      b = 8'(i * 8'h11);
      send_byte(b);
    end
    wait_done(19'd8, 1'b1);

    // Zero count completes with no write
    start(17'h00050, 19'd0);
    wait_done(19'd0, 1'b0);

    // Reset after three bytes discards the partial word
    start(17'h00060, 19'd8);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    reset = 1'b1;
    tick();
    check_all_zero("reset_midword");
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) tick();
    in_valid = 1'b0;
    check_all_zero("idle_after_reset");

    expect_wr(17'h00070, 32'hD4C3B2A1, 4'hF);
    start(17'h00070, 19'd4);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    wait_done(19'd4, 1'b1);

    repeat (5) tick();
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_mem_writer.md
Name: uart_rx_mem_writer

Overview:
- Upstream feeder for the 32-bit single-port on-chip memory: accepts the UART receive byte stream, packs bytes little-endian into 32-bit words, and issues one-cycle Avalon-MM writes with byteenable.
- Firmware sets a base word address and a byte count, pulses start, and waits for done.
- Partial words (end of count or explicit flush) are written with only the filled lanes enabled.

Parameters:
- ADDR_W, 17, word-address width of the target memory.
- DEPTH, 100000, number of words in the target memory; the address wraps from DEPTH-1 to 0.
- CNT_W, 19, width of the byte counters (must hold 4*DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; begin a transfer
- cfg_base_addr  in  ADDR_W  first word address, latched on an accepted cfg_start
- cfg_byte_count  in  CNT_W  bytes to transfer, latched on an accepted cfg_start
- flush  in  1  force write-out of a partially filled word
- in_data  in  8  received byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a byte when in_valid&in_ready
- mem_address  out  ADDR_W  word address to memory
- mem_byteenable  out  4  lane enables
- mem_chipselect  out  1  memory select
- mem_write  out  1  write strobe
- mem_writedata  out  32  packed word
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- bytes_written  out  CNT_W  bytes committed to memory in the current/last transfer

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters, lane index, data and enable shift registers cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: in_ready=0, busy=0.
  - cfg_start with cfg_byte_count!=0: latch base address and count; clear bytes_written, lane=0 and be=0; go to COLLECT.
  - cfg_start with count==0: go to DONE (done asserts the next cycle) with no write.
- COLLECT: in_ready=1, busy=1.
  - On each accepted byte: store it in lane[lane] (lane 0 = writedata[7:0]), set be[lane], lane++, remaining--.
  - Go to WRITE when the byte fills lane 3 or remaining reaches 0.
  - flush while lane>0: go to WRITE. flush while lane==0: ignored.
  - flush in the same cycle as an accepted byte: the byte is included first, then the word is written.
- WRITE: exactly one cycle with mem_chipselect=mem_write=1, mem_address=current address, mem_writedata=packed word, mem_byteenable=be.
  - Unfilled lanes carry 0 data with their enable bit 0.
  - in_ready=0 during this cycle.
  - The memory has no waitrequest; the write commits that cycle.
  - On the next edge: bytes_written += popcount(be); address increments, or wraps to 0 if it was DEPTH-1; lane and be clear.
  - Next state is DONE if remaining==0, else COLLECT.
- DONE: done=1 for one cycle, busy=0, in_ready=0; then return to IDLE. bytes_written holds until the next accepted cfg_start.
- Whenever no write is in progress, mem_chipselect, mem_write and mem_byteenable are 0. mem_address and mem_writedata hold their last value.
- cfg_start when not in IDLE: ignored; latched configuration is unchanged.
- Throughput: 4 bytes per 5 cycles at full in_valid rate; in_ready drops for one cycle per word.
- Reset mid-transfer: no write is issued in or after the reset cycle; any partial word is discarded; done is not asserted.
- Arithmetic: remaining and bytes_written are CNT_W-bit unsigned with no wrap (count is bounded by the configuration).

Test Plan:
- Base 0x00010, count 8, bytes 0x11..0x88 back-to-back -> writes (0x10, 0x44332211, be 0xF) and (0x11, 0x88776655, be 0xF); in_ready low exactly in both WRITE cycles; done one cycle after the second write; bytes_written=8.
- Count 6, bytes 0x11..0x66 -> second write at base+1 with data 0x00006655, be 0x3; bytes_written=6.
- Count 10; flush after 2 bytes (0xA1, 0xA2) -> write data 0x0000A2A1, be 0x3; next byte lands in lane 0 of base+1; flush with lane==0 -> no write.
- Base 99999, count 8 -> writes at 99999 then 0.
- Random in_valid gaps plus cfg_start pulsed mid-transfer -> identical memory contents to the gap-free run; second start ignored. Count 0 -> done asserts with no mem_write.
- Reset asserted after 3 bytes of a word -> no write; all outputs 0. A new start then writes correctly from lane 0.
